// File: rtl/dispatch_queue_pkg.sv
// Shared types for the dispatch queue: unit classes, the stored entry
// layout and the lane numbering helpers.
package dispatch_queue_pkg;

    // Operand and tag widths live here because the entry struct is built on them.
    localparam int DQ_DATA_W = 16;
    localparam int DQ_TAG_W  = 4;
    localparam int DQ_OPC_W  = 4;

    typedef enum logic [1:0] {
        CLS_FXU = 2'd0,
        CLS_LSU = 2'd1,
        CLS_BR  = 2'd2
    } unit_class_e;

    typedef struct packed {
        logic                 valid;
        unit_class_e          cls;
        logic [DQ_OPC_W-1:0]  opcode;
        logic [DQ_TAG_W-1:0]  rob_tag;
        logic                 a_ready;
        logic [DQ_DATA_W-1:0] a_value;
        logic [DQ_TAG_W-1:0]  a_owner;
        logic                 b_ready;
        logic [DQ_DATA_W-1:0] b_value;
        logic [DQ_TAG_W-1:0]  b_owner;
    } dq_entry_t;

    // Lane layout: FXU lanes first, then one LSU lane, then one BR lane.
    localparam int LANE_LSU_OFS = 0;
    localparam int LANE_BR_OFS  = 1;

    function automatic int lane_lsu(input int num_fxu);
        return num_fxu + LANE_LSU_OFS;
    endfunction

    function automatic int lane_br(input int num_fxu);
        return num_fxu + LANE_BR_OFS;
    endfunction

    // The unused class encoding 3 is steered to the FXU lanes.
    function automatic unit_class_e decode_class(input logic [1:0] raw);
        return (raw == 2'd3) ? CLS_FXU : unit_class_e'(raw);
    endfunction

endpackage

// File: rtl/dispatch_queue_cdb_match.sv
// dq_cdb_match: looks one tag up across all CDB broadcasts of this cycle.
module dq_cdb_match #(
    parameter int CDB_N  = 2,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic [TAG_W-1:0]        tag_i,
    input  logic [CDB_N-1:0]        cdb_valid_i,
    input  logic [CDB_N*TAG_W-1:0]  cdb_tag_i,
    input  logic [CDB_N*DATA_W-1:0] cdb_value_i,
    output logic                    hit_o,
    output logic [DATA_W-1:0]       value_o
);

    // Scan from the top index down so the lowest matching broadcast wins.
    always_comb begin
        hit_o   = 1'b0;
        value_o = '0;
        for (int j = CDB_N - 1; j >= 0; j--) begin
            if (cdb_valid_i[j] && (cdb_tag_i[j*TAG_W +: TAG_W] == tag_i)) begin
                hit_o   = 1'b1;
                value_o = cdb_value_i[j*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order circular dispatch queue with CDB wakeup and
// oldest-first multi-lane dispatch.
// Optional build macro DISPATCH_QUEUE_PERF_EN adds three saturating
// performance counters (perf_stall_operand, perf_stall_unit, perf_full_cycles).
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int IN_W    = 4,
    parameter  int NUM_FXU = 2,
    parameter  int CDB_N   = 2,
    localparam int DATA_W  = DQ_DATA_W,
    localparam int TAG_W   = DQ_TAG_W,
    localparam int OPC_W   = DQ_OPC_W,
    localparam int L       = NUM_FXU + 2,
    localparam int CNT_W   = $clog2(IN_W + 1),
    localparam int OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [CNT_W-1:0]        in_count,
    output logic                    in_accept,
    input  logic [IN_W*2-1:0]       in_class,
    input  logic [IN_W*OPC_W-1:0]   in_opcode,
    input  logic [IN_W*TAG_W-1:0]   in_rob_tag,
    input  logic [IN_W-1:0]         in_a_valid,
    input  logic [IN_W-1:0]         in_b_valid,
    input  logic [IN_W*DATA_W-1:0]  in_a_value,
    input  logic [IN_W*DATA_W-1:0]  in_b_value,
    input  logic [IN_W*TAG_W-1:0]   in_a_owner,
    input  logic [IN_W*TAG_W-1:0]   in_b_owner,
    input  logic [CDB_N-1:0]        cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
    input  logic [CDB_N*DATA_W-1:0] cdb_value,
    input  logic [L-1:0]            unit_full,
    output logic [L-1:0]            out_valid,
    output logic [L*OPC_W-1:0]      out_opcode,
    output logic [L*TAG_W-1:0]      out_rob_tag,
    output logic [L*DATA_W-1:0]     out_a_value,
    output logic [L*DATA_W-1:0]     out_b_value,
`ifdef DISPATCH_QUEUE_PERF_EN
    output logic [31:0]             perf_stall_operand,
    output logic [31:0]             perf_stall_unit,
    output logic [31:0]             perf_full_cycles,
`endif
    output logic [OCC_W-1:0]        occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int DSP_W = $clog2(L + 1);

    dq_entry_t         entries_q [DEPTH];
    dq_entry_t         entries_d [DEPTH];
    dq_entry_t         slot_entry [IN_W];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [DSP_W-1:0]  disp_cnt;

    logic [DEPTH-1:0]  ent_a_hit, ent_b_hit;
    logic [DATA_W-1:0] ent_a_val [DEPTH];
    logic [DATA_W-1:0] ent_b_val [DEPTH];
    logic [IN_W-1:0]   in_a_hit, in_b_hit;
    logic [DATA_W-1:0] in_a_cdb [IN_W];
    logic [DATA_W-1:0] in_b_cdb [IN_W];

    logic [L-1:0]      claimed;
    logic [PTR_W-1:0]  scan_idx;
    logic              scan_go, scan_a_rdy, scan_b_rdy, lane_found;
    int                lane_sel;

    // CDB lookups for every stored operand (wakeup and same-cycle bypass).
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent_match
        dq_cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_a (
            .tag_i(entries_q[gi].a_owner), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_value_i(cdb_value), .hit_o(ent_a_hit[gi]), .value_o(ent_a_val[gi]));
        dq_cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_b (
            .tag_i(entries_q[gi].b_owner), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_value_i(cdb_value), .hit_o(ent_b_hit[gi]), .value_o(ent_b_val[gi]));
    end

    // CDB lookups for incoming operands so a result racing rename is not lost.
    for (genvar gi = 0; gi < IN_W; gi++) begin : g_in_match
        dq_cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_a (
            .tag_i(in_a_owner[gi*TAG_W +: TAG_W]), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_value_i(cdb_value), .hit_o(in_a_hit[gi]), .value_o(in_a_cdb[gi]));
        dq_cdb_match #(.CDB_N(CDB_N), .DATA_W(DATA_W), .TAG_W(TAG_W)) u_b (
            .tag_i(in_b_owner[gi*TAG_W +: TAG_W]), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
            .cdb_value_i(cdb_value), .hit_o(in_b_hit[gi]), .value_o(in_b_cdb[gi]));
    end

    // Whole group or nothing; slots freed by this cycle's dispatch are not counted.
    assign in_accept = !rst && !flush && (int'(in_count) <= DEPTH - int'(occ_q));
    assign occupancy = occ_q;

    // Build the entry each input slot would be written as, with capture wakeup.
    always_comb begin
        for (int i = 0; i < IN_W; i++) begin
            slot_entry[i].valid   = 1'b1;
            slot_entry[i].cls     = decode_class(in_class[i*2 +: 2]);
            slot_entry[i].opcode  = in_opcode[i*OPC_W +: OPC_W];
            slot_entry[i].rob_tag = in_rob_tag[i*TAG_W +: TAG_W];
            slot_entry[i].a_ready = in_a_valid[i] | in_a_hit[i];
            slot_entry[i].a_value = in_a_valid[i] ? in_a_value[i*DATA_W +: DATA_W] : in_a_cdb[i];
            slot_entry[i].a_owner = in_a_owner[i*TAG_W +: TAG_W];
            slot_entry[i].b_ready = in_b_valid[i] | in_b_hit[i];
            slot_entry[i].b_value = in_b_valid[i] ? in_b_value[i*DATA_W +: DATA_W] : in_b_cdb[i];
            slot_entry[i].b_owner = in_b_owner[i*TAG_W +: TAG_W];
        end
    end

    // Oldest-first scan of the first L entries; stops at the first entry that cannot go.
    always_comb begin
        out_valid   = '0;
        out_opcode  = '0;
        out_rob_tag = '0;
        out_a_value = '0;
        out_b_value = '0;
        disp_cnt    = '0;
        claimed     = '0;
        scan_go     = !rst && !flush;
        scan_idx    = head_q;
        scan_a_rdy  = 1'b0;
        scan_b_rdy  = 1'b0;
        lane_found  = 1'b0;
        lane_sel    = 0;
        for (int k = 0; k < L; k++) begin
            scan_idx   = head_q + PTR_W'(k);
            scan_a_rdy = entries_q[scan_idx].a_ready | ent_a_hit[scan_idx];
            scan_b_rdy = entries_q[scan_idx].b_ready | ent_b_hit[scan_idx];
            lane_found = 1'b0;
            lane_sel   = 0;
            case (entries_q[scan_idx].cls)
                CLS_LSU: if (!unit_full[lane_lsu(NUM_FXU)] && !claimed[lane_lsu(NUM_FXU)]) begin
                    lane_found = 1'b1;
                    lane_sel   = lane_lsu(NUM_FXU);
                end
                CLS_BR: if (!unit_full[lane_br(NUM_FXU)] && !claimed[lane_br(NUM_FXU)]) begin
                    lane_found = 1'b1;
                    lane_sel   = lane_br(NUM_FXU);
                end
                default: for (int l = 0; l < NUM_FXU; l++) begin
                    if (!lane_found && !unit_full[l] && !claimed[l]) begin
                        lane_found = 1'b1;
                        lane_sel   = l;
                    end
                end
            endcase
            if (scan_go && entries_q[scan_idx].valid && scan_a_rdy && scan_b_rdy && lane_found) begin
                claimed[lane_sel]                       = 1'b1;
                out_valid[lane_sel]                     = 1'b1;
                out_opcode[lane_sel*OPC_W +: OPC_W]     = entries_q[scan_idx].opcode;
                out_rob_tag[lane_sel*TAG_W +: TAG_W]    = entries_q[scan_idx].rob_tag;
                out_a_value[lane_sel*DATA_W +: DATA_W]  = entries_q[scan_idx].a_ready ?
                                                          entries_q[scan_idx].a_value : ent_a_val[scan_idx];
                out_b_value[lane_sel*DATA_W +: DATA_W]  = entries_q[scan_idx].b_ready ?
                                                          entries_q[scan_idx].b_value : ent_b_val[scan_idx];
                disp_cnt                                = disp_cnt + DSP_W'(1);
            end else begin
                scan_go = 1'b0;
            end
        end
    end

    // Next state: pop dispatched entries, wake stored operands, append accepted group.
    always_comb begin
        entries_d = entries_q;
        for (int k = 0; k < L; k++) begin
            if (DSP_W'(k) < disp_cnt) begin
                entries_d[head_q + PTR_W'(k)].valid = 1'b0;
            end
        end
        for (int n = 0; n < DEPTH; n++) begin
            if (entries_q[n].valid && !entries_q[n].a_ready && ent_a_hit[n]) begin
                entries_d[n].a_ready = 1'b1;
                entries_d[n].a_value = ent_a_val[n];
            end
            if (entries_q[n].valid && !entries_q[n].b_ready && ent_b_hit[n]) begin
                entries_d[n].b_ready = 1'b1;
                entries_d[n].b_value = ent_b_val[n];
            end
        end
        if (in_accept) begin
            for (int i = 0; i < IN_W; i++) begin
                if (CNT_W'(i) < in_count) begin
                    entries_d[tail_q + PTR_W'(i)] = slot_entry[i];
                end
            end
        end
        head_d = head_q + PTR_W'(disp_cnt);
        tail_d = in_accept ? tail_q + PTR_W'(in_count) : tail_q;
        occ_d  = occ_q + (in_accept ? OCC_W'(in_count) : OCC_W'(0)) - OCC_W'(disp_cnt);
    end

    // Queue state registers; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int n = 0; n < DEPTH; n++) begin
                entries_q[n].valid <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            entries_q <= entries_d;
        end
    end

`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] perf_op_q, perf_unit_q, perf_full_q;
    logic        head_valid, head_rdy, head_lane_free;

    // Classify why the head entry is not leaving this cycle.
    always_comb begin
        head_valid = entries_q[head_q].valid && (occ_q != '0);
        head_rdy   = (entries_q[head_q].a_ready | ent_a_hit[head_q]) &&
                     (entries_q[head_q].b_ready | ent_b_hit[head_q]);
        case (entries_q[head_q].cls)
            CLS_LSU: head_lane_free = !unit_full[lane_lsu(NUM_FXU)];
            CLS_BR:  head_lane_free = !unit_full[lane_br(NUM_FXU)];
            default: head_lane_free = !(&unit_full[NUM_FXU-1:0]);
        endcase
    end

    // Saturating counters; cleared by reset, frozen during a flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_op_q   <= '0;
            perf_unit_q <= '0;
            perf_full_q <= '0;
        end else if (!flush) begin
            if (head_valid && !head_rdy && (perf_op_q != '1)) perf_op_q <= perf_op_q + 32'd1;
            if (head_valid && head_rdy && !head_lane_free && (perf_unit_q != '1)) perf_unit_q <= perf_unit_q + 32'd1;
            if ((occ_q == OCC_W'(DEPTH)) && (perf_full_q != '1)) perf_full_q <= perf_full_q + 32'd1;
        end
    end

    assign perf_stall_operand = perf_op_q;
    assign perf_stall_unit    = perf_unit_q;
    assign perf_full_cycles   = perf_full_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Testbench for dispatch_queue: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_dispatch_queue;

    localparam int DEPTH = 8, IN_W = 4, NUM_FXU = 2, L = 4, CDB_N = 2;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  in_count;
    logic        in_accept;
    logic [7:0]  in_class;
    logic [15:0] in_opcode, in_rob_tag, in_a_owner, in_b_owner;
    logic [3:0]  in_a_valid, in_b_valid;
    logic [63:0] in_a_value, in_b_value;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic [3:0]  unit_full, out_valid;
    logic [15:0] out_opcode, out_rob_tag;
    logic [63:0] out_a_value, out_b_value;
    logic [3:0]  occupancy;
`ifdef DISPATCH_QUEUE_PERF_EN
    logic [31:0] perf_stall_operand, perf_stall_unit, perf_full_cycles;
`endif

    int checks = 0;
    int errors = 0;

    dispatch_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .NUM_FXU(NUM_FXU), .CDB_N(CDB_N)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_count(in_count), .in_accept(in_accept),
        .in_class(in_class), .in_opcode(in_opcode), .in_rob_tag(in_rob_tag),
        .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
        .in_a_value(in_a_value), .in_b_value(in_b_value),
        .in_a_owner(in_a_owner), .in_b_owner(in_b_owner),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .unit_full(unit_full), .out_valid(out_valid), .out_opcode(out_opcode),
        .out_rob_tag(out_rob_tag), .out_a_value(out_a_value), .out_b_value(out_b_value),
`ifdef DISPATCH_QUEUE_PERF_EN
        .perf_stall_operand(perf_stall_operand), .perf_stall_unit(perf_stall_unit),
        .perf_full_cycles(perf_full_cycles),
`endif
        .occupancy(occupancy));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_count = '0; in_class = '0; in_opcode = '0;
        in_rob_tag = '0; in_a_valid = '1; in_b_valid = '1; in_a_value = '0; in_b_value = '0;
        in_a_owner = '0; in_b_owner = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        unit_full = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        bit         flush;
        logic [2:0] cnt;
        logic [7:0] cls;
        logic [3:0] full;
        bit         acc;
        logic [3:0] ov;
        logic [3:0] occ;
    } vec_t;

    vec_t vt[26];

    // ---------------- reference model ----------------
    typedef struct {
        int          cls;
        logic [3:0]  op;
        logic [3:0]  tag;
        bit          ar;
        logic [15:0] av;
        logic [3:0]  ao;
        bit          br;
        logic [15:0] bv;
        logic [3:0]  bo;
    } mq_t;

    mq_t mq[$];

    function automatic void cdb_look(input logic [3:0] t, output bit hit, output logic [15:0] v);
        hit = 1'b0;
        v   = '0;
        for (int j = 0; j < CDB_N; j++) begin
            if (!hit && cdb_valid[j] && cdb_tag[j*4 +: 4] == t) begin
                hit = 1'b1;
                v   = cdb_value[j*16 +: 16];
            end
        end
    endfunction

    task automatic random_cycle(input int n, input bit force_rst);
        bit          exp_acc, ha, hb, stop;
        logic [3:0]  exp_ov, claimed;
        logic [39:0] exp_f [L];
        logic [15:0] va, vb;
        int          ndisp, lane, raw;
        mq_t         e;

        rst   = force_rst || ($urandom_range(0, 199) == 0);
        flush = ($urandom_range(0, 39) == 0);
        in_count = 3'($urandom_range(0, 4));
        for (int i = 0; i < IN_W; i++) begin
            in_class[i*2 +: 2]    = 2'($urandom_range(0, 3));
            in_opcode[i*4 +: 4]   = 4'($urandom);
            in_rob_tag[i*4 +: 4]  = 4'($urandom);
            in_a_valid[i]         = ($urandom_range(0, 9) < 6);
            in_b_valid[i]         = ($urandom_range(0, 9) < 6);
            in_a_value[i*16 +: 16] = 16'($urandom);
            in_b_value[i*16 +: 16] = 16'($urandom);
            in_a_owner[i*4 +: 4]  = 4'($urandom_range(0, 7));
            in_b_owner[i*4 +: 4]  = 4'($urandom_range(0, 7));
        end
        cdb_valid = 2'($urandom);
        cdb_tag   = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
        cdb_value = $urandom;
        unit_full = 4'($urandom & $urandom);
        #4;

        exp_acc = !rst && !flush && (int'(in_count) <= DEPTH - mq.size());
        exp_ov = '0; claimed = '0; ndisp = 0; stop = 1'b0;
        for (int l = 0; l < L; l++) exp_f[l] = '0;
        if (!rst && !flush) begin
            for (int k = 0; k < mq.size() && k < L && !stop; k++) begin
                e = mq[k];
                cdb_look(e.ao, ha, va);
                cdb_look(e.bo, hb, vb);
                lane = -1;
                if (e.cls == 1) begin
                    if (!unit_full[NUM_FXU] && !claimed[NUM_FXU]) lane = NUM_FXU;
                end else if (e.cls == 2) begin
                    if (!unit_full[NUM_FXU+1] && !claimed[NUM_FXU+1]) lane = NUM_FXU + 1;
                end else begin
                    for (int l = NUM_FXU - 1; l >= 0; l--)
                        if (!unit_full[l] && !claimed[l]) lane = l;
                end
                if (!(e.ar || ha) || !(e.br || hb) || lane < 0) begin
                    stop = 1'b1;
                end else begin
                    claimed[lane] = 1'b1;
                    exp_ov[lane]  = 1'b1;
                    exp_f[lane]   = {e.op, e.tag, e.ar ? e.av : va, e.br ? e.bv : vb};
                    ndisp++;
                end
            end
        end

        check("rnd_accept", 64'(in_accept), 64'(exp_acc));
        check("rnd_out_valid", 64'(out_valid), 64'(exp_ov));
        check("rnd_occupancy", 64'(occupancy), 64'(mq.size()));
        for (int l = 0; l < L; l++) begin
            if (exp_ov[l]) begin
                check($sformatf("rnd_lane%0d_fields", l),
                      {24'd0, out_opcode[l*4 +: 4], out_rob_tag[l*4 +: 4],
                       out_a_value[l*16 +: 16], out_b_value[l*16 +: 16]}, {24'd0, exp_f[l]});
            end
        end
        $display("rnd %0d: rst=%0b flush=%0b cnt=%0d acc=%0b ov=%b occ=%0d", n, rst, flush,
                 in_count, in_accept, out_valid, occupancy);

        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            repeat (ndisp) void'(mq.pop_front());
            foreach (mq[q]) begin
                cdb_look(mq[q].ao, ha, va);
                cdb_look(mq[q].bo, hb, vb);
                if (!mq[q].ar && ha) begin mq[q].ar = 1'b1; mq[q].av = va; end
                if (!mq[q].br && hb) begin mq[q].br = 1'b1; mq[q].bv = vb; end
            end
            if (exp_acc) begin
                for (int i = 0; i < int'(in_count); i++) begin
                    raw   = int'(in_class[i*2 +: 2]);
                    e.cls = (raw == 3) ? 0 : raw;
                    e.op  = in_opcode[i*4 +: 4];
                    e.tag = in_rob_tag[i*4 +: 4];
                    cdb_look(in_a_owner[i*4 +: 4], ha, va);
                    cdb_look(in_b_owner[i*4 +: 4], hb, vb);
                    e.ao = in_a_owner[i*4 +: 4];
                    e.bo = in_b_owner[i*4 +: 4];
                    e.ar = in_a_valid[i] || ha;
                    e.av = in_a_valid[i] ? in_a_value[i*16 +: 16] : va;
                    e.br = in_b_valid[i] || hb;
                    e.bv = in_b_valid[i] ? in_b_value[i*16 +: 16] : vb;
                    mq.push_back(e);
                end
            end
        end
        #1;
    endtask

    initial begin
        //           rst   flush cnt   cls    full  acc   ov     occ
        vt[0]  = '{1'b1, 1'b0, 3'd4, 8'h00, 4'h0, 1'b0, 4'h0, 4'd0};  // reset state
        vt[1]  = '{1'b0, 1'b0, 3'd4, 8'h00, 4'h0, 1'b1, 4'h0, 4'd0};  // 4 FXU in
        vt[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h3, 4'd4};
        vt[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h3, 4'd2};
        vt[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h0, 4'd0};
        vt[5]  = '{1'b0, 1'b0, 3'd4, 8'h08, 4'h0, 1'b1, 4'h0, 4'd0};  // FXU BR FXU FXU
        vt[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h1, 1'b1, 4'hA, 4'd4};
        vt[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h3, 4'd2};
        vt[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h0, 4'd0};
        vt[9]  = '{1'b0, 1'b0, 3'd4, 8'h00, 4'hF, 1'b1, 4'h0, 4'd0};  // fill
        vt[10] = '{1'b0, 1'b0, 3'd4, 8'h00, 4'hF, 1'b1, 4'h0, 4'd4};
        vt[11] = '{1'b0, 1'b0, 3'd1, 8'h00, 4'hF, 1'b0, 4'h0, 4'd8};  // full
        vt[12] = '{1'b0, 1'b0, 3'd1, 8'h00, 4'hE, 1'b0, 4'h1, 4'd8};  // one pops
        vt[13] = '{1'b0, 1'b0, 3'd1, 8'h00, 4'hF, 1'b1, 4'h0, 4'd7};  // tail wraps
        vt[14] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'hF, 1'b1, 4'h0, 4'd8};
        vt[15] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h3, 4'd8};
        vt[16] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h3, 4'd6};
        vt[17] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h3, 4'd4};
        vt[18] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h3, 4'd2};
        vt[19] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h0, 4'd0};
        vt[20] = '{1'b0, 1'b0, 3'd4, 8'h00, 4'hF, 1'b1, 4'h0, 4'd0};  // flush setup
        vt[21] = '{1'b0, 1'b0, 3'd1, 8'h00, 4'hF, 1'b1, 4'h0, 4'd4};
        vt[22] = '{1'b0, 1'b1, 3'd3, 8'h00, 4'h0, 1'b0, 4'h0, 4'd5};  // flush
        vt[23] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h0, 4'd0};
        vt[24] = '{1'b1, 1'b1, 3'd2, 8'h00, 4'h0, 1'b0, 4'h0, 4'd0};  // flush + rst
        vt[25] = '{1'b0, 1'b0, 3'd0, 8'h00, 4'h0, 1'b1, 4'h0, 4'd0};

        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();

        for (int r = 0; r < 26; r++) begin
            idle_inputs();
            rst = vt[r].rst; flush = vt[r].flush; in_count = vt[r].cnt;
            in_class = vt[r].cls; unit_full = vt[r].full;
            for (int i = 0; i < IN_W; i++) begin
                in_opcode[i*4 +: 4]    = 4'(r + i);
                in_rob_tag[i*4 +: 4]   = 4'(i);
                in_a_value[i*16 +: 16] = 16'(r * 16 + i);
                in_b_value[i*16 +: 16] = 16'(r * 16 + i + 8);
            end
            #4;
            check($sformatf("vec%0d_accept", r), 64'(in_accept), 64'(vt[r].acc));
            check($sformatf("vec%0d_out_valid", r), 64'(out_valid), 64'(vt[r].ov));
            check($sformatf("vec%0d_occupancy", r), 64'(occupancy), 64'(vt[r].occ));
            $display("vec %0d: acc=%0b ov=%b occ=%0d", r, in_accept, out_valid, occupancy);
            next_cycle();
        end

        // Bypass: unready operand at head, woken by a same-cycle broadcast.
        idle_inputs(); rst = 1'b1; #4; next_cycle();
        idle_inputs(); in_count = 3'd1; in_opcode[3:0] = 4'hA; in_rob_tag[3:0] = 4'd3;
        in_a_valid[0] = 1'b0; in_a_owner[3:0] = 4'd5; in_b_value[15:0] = 16'h0B0B;
        #4; check("byp_enq_accept", 64'(in_accept), 64'd1); next_cycle();
        idle_inputs();
        for (int c = 0; c < 7; c++) begin
            #4; check($sformatf("byp_wait%0d_out_valid", c), 64'(out_valid), 64'd0);
            $display("bypass wait %0d: ov=%b", c, out_valid);
            next_cycle();
        end
        cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_value = {16'hBEEF, 16'h1234};
        #4;
        check("byp_out_valid", 64'(out_valid), 64'h1);
        check("byp_a_value", 64'(out_a_value[15:0]), 64'h1234);
        check("byp_b_value", 64'(out_b_value[15:0]), 64'h0B0B);
        check("byp_opcode", 64'(out_opcode[3:0]), 64'hA);
`ifdef DISPATCH_QUEUE_PERF_EN
        check("perf_stall_operand", 64'(perf_stall_operand), 64'd7);
`endif
        $display("bypass: ov=%b a=%h", out_valid, out_a_value[15:0]);
        next_cycle();
        idle_inputs(); #4;
        check("byp_after_occupancy", 64'(occupancy), 64'd0);
        next_cycle();

        // Capture wakeup: both operands resolved by broadcasts during enqueue.
        idle_inputs(); in_count = 3'd1; in_a_valid[0] = 1'b0; in_a_owner[3:0] = 4'd9;
        in_b_valid[0] = 1'b0; in_b_owner[3:0] = 4'd6;
        cdb_valid = 2'b11; cdb_tag = {4'd6, 4'd9}; cdb_value = {16'h6666, 16'h55AA};
        #4; check("cap_accept", 64'(in_accept), 64'd1); next_cycle();
        idle_inputs(); #4;
        check("cap_out_valid", 64'(out_valid), 64'h1);
        check("cap_values", {32'd0, out_a_value[15:0], out_b_value[15:0]}, 64'h55AA_6666);
        $display("capture: ov=%b a=%h b=%h", out_valid, out_a_value[15:0], out_b_value[15:0]);
        next_cycle();

        // Stored wakeup: broadcast arrives while the lanes are blocked.
        idle_inputs(); in_count = 3'd1; in_a_valid[0] = 1'b0; in_a_owner[3:0] = 4'd7;
        unit_full = 4'hF; #4; next_cycle();
        idle_inputs(); unit_full = 4'hF; cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd0};
        cdb_value = {16'h7777, 16'h0000};
        #4; check("wake_blocked_out_valid", 64'(out_valid), 64'd0); next_cycle();
        idle_inputs(); #4;
        check("wake_out_valid", 64'(out_valid), 64'h1);
        check("wake_a_value", 64'(out_a_value[15:0]), 64'h7777);
        $display("stored wakeup: ov=%b a=%h", out_valid, out_a_value[15:0]);
        next_cycle();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) random_cycle(n, n == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
